// File: rtl/fb_wr_if.sv
// Pixel-write request channel into the framebuffer write engine.
// The producer drives valid/coordinates/colour; the engine returns ready.
interface fb_wr_if #(
  parameter int HPOS_WIDTH = 10,
  parameter int VPOS_WIDTH = 10,
  parameter int RGB_WIDTH  = 3
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [HPOS_WIDTH-1:0] wr_hpos;
  logic [VPOS_WIDTH-1:0] wr_vpos;
  logic [RGB_WIDTH-1:0]  wr_rgb;

  modport master (output wr_valid, output wr_hpos, output wr_vpos, output wr_rgb, input wr_ready);
  modport slave  (input wr_valid, input wr_hpos, input wr_vpos, input wr_rgb, output wr_ready);
endinterface

// File: rtl/fb_write_engine.sv
// Framebuffer write engine: queues pixel writes, scales them to the RAM grid and drains
// them into the RAM port while the write window is open; also owns the RAM clear sweep.
module fb_write_engine #(
  parameter int                   HPOS_WIDTH  = 10,
  parameter int                   VPOS_WIDTH  = 10,
  parameter int                   RGB_WIDTH   = 3,
  parameter int                   FIFO_DEPTH  = 16,
  parameter int                   SCALE_SHIFT = 3,
  parameter int                   RAM_H       = 80,
  parameter int                   RAM_V       = 60,
  parameter logic [RGB_WIDTH-1:0] INITIAL_RGB = 3'b111,
  parameter bit                   DUAL_PORT   = 1'b0,
  localparam int                  ADDR_WIDTH  = $clog2(RAM_H * RAM_V),
  localparam int                  LVL_WIDTH   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  display_on,
  input  logic                  clear_req,
  fb_wr_if.slave                wr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [RGB_WIDTH-1:0]  mem_wdata,
  output logic                  busy,
  output logic [LVL_WIDTH-1:0]  level,
  output logic [7:0]            drop_cnt
);
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W   = ADDR_WIDTH + RGB_WIDTH;
  localparam int unsigned H_LIMIT = RAM_H << SCALE_SHIFT;
  localparam int unsigned V_LIMIT = RAM_V << SCALE_SHIFT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_H * RAM_V - 1);
  localparam logic [LVL_WIDTH-1:0]  FULL_LVL  = LVL_WIDTH'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 state_r;
  logic [ADDR_WIDTH-1:0]  cnt_r;
  logic [PTR_WIDTH-1:0]   wptr_r;
  logic [PTR_WIDTH-1:0]   rptr_r;
  logic [LVL_WIDTH-1:0]   count_r;
  logic                   wr_ready_r;
  logic                   mem_we_r;
  logic [ADDR_WIDTH-1:0]  mem_addr_r;
  logic [RGB_WIDTH-1:0]   mem_wdata_r;
  logic                   busy_r;
  logic [7:0]             drop_cnt_r;
  logic [ENTRY_W-1:0]     fifo_r [FIFO_DEPTH];

  logic                   win_s;
  logic                   run_s;
  logic                   in_range_s;
  logic                   accept_s;
  logic                   push_s;
  logic                   drop_s;
  logic                   pop_s;
  logic [HPOS_WIDTH-1:0]  hpos_s;
  logic [VPOS_WIDTH-1:0]  vpos_s;
  logic [ADDR_WIDTH-1:0]  scaled_addr_s;
  logic [ENTRY_W-1:0]     head_s;
  logic [LVL_WIDTH-1:0]   level_next_s;

  // Handshake qualification, address scaling and FIFO bookkeeping for this cycle.
  always_comb begin
    win_s = 1'b0;
    if (DUAL_PORT) begin
      win_s = 1'b1;
    end else begin
      win_s = ~display_on;
    end
    hpos_s        = wr.wr_hpos;
    vpos_s        = wr.wr_vpos;
    run_s         = (state_r == ST_RUN);
    in_range_s    = (32'(hpos_s) < H_LIMIT) && (32'(vpos_s) < V_LIMIT);
    scaled_addr_s = ADDR_WIDTH'(32'(vpos_s >> SCALE_SHIFT) * 32'(RAM_H)
                              + 32'(hpos_s >> SCALE_SHIFT));
    // A request colliding with clear_req is refused: the flush wins.
    accept_s      = run_s & wr.wr_valid & wr_ready_r & ~clear_req;
    push_s        = accept_s & in_range_s;
    drop_s        = accept_s & ~in_range_s;
    pop_s         = run_s & win_s & (count_r != LVL_WIDTH'(0)) & ~clear_req;
    head_s        = fifo_r[rptr_r];
    level_next_s  = count_r + LVL_WIDTH'(push_s) - LVL_WIDTH'(pop_s);
  end

  // Request storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wptr_r] <= {scaled_addr_s, wr.wr_rgb};
    end
  end

  // Clear/run state machine with registered RAM port, handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_CLEAR;
      cnt_r       <= ADDR_WIDTH'(0);
      wptr_r      <= PTR_WIDTH'(0);
      rptr_r      <= PTR_WIDTH'(0);
      count_r     <= LVL_WIDTH'(0);
      wr_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= ADDR_WIDTH'(0);
      mem_wdata_r <= RGB_WIDTH'(0);
      busy_r      <= 1'b1;
      drop_cnt_r  <= 8'd0;
    end else begin
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
      case (state_r)
        ST_CLEAR: begin
          wr_ready_r <= 1'b0;
          busy_r     <= 1'b1;
          if (clear_req) begin
            cnt_r    <= ADDR_WIDTH'(0);
            mem_we_r <= 1'b0;
          end else if (win_s) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= cnt_r;
            mem_wdata_r <= INITIAL_RGB;
            if (cnt_r == LAST_ADDR) begin
              state_r    <= ST_RUN;
              busy_r     <= 1'b0;
              wr_ready_r <= 1'b1;
              cnt_r      <= ADDR_WIDTH'(0);
            end else begin
              cnt_r <= cnt_r + ADDR_WIDTH'(1);
            end
          end else begin
            mem_we_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (clear_req) begin
            state_r    <= ST_CLEAR;
            cnt_r      <= ADDR_WIDTH'(0);
            busy_r     <= 1'b1;
            wr_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            wptr_r     <= PTR_WIDTH'(0);
            rptr_r     <= PTR_WIDTH'(0);
            count_r    <= LVL_WIDTH'(0);
          end else begin
            mem_we_r <= pop_s;
            if (pop_s) begin
              mem_addr_r  <= head_s[ENTRY_W-1:RGB_WIDTH];
              mem_wdata_r <= head_s[RGB_WIDTH-1:0];
              rptr_r      <= rptr_r + PTR_WIDTH'(1);
            end
            if (push_s) begin
              wptr_r <= wptr_r + PTR_WIDTH'(1);
            end
            count_r    <= level_next_s;
            wr_ready_r <= (level_next_s != FULL_LVL);
          end
        end
        default: begin
          state_r    <= ST_CLEAR;
          cnt_r      <= ADDR_WIDTH'(0);
          busy_r     <= 1'b1;
          wr_ready_r <= 1'b0;
          mem_we_r   <= 1'b0;
        end
      endcase
    end
  end

  assign wr.wr_ready = wr_ready_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign busy        = busy_r;
  assign level       = count_r;
  assign drop_cnt    = drop_cnt_r;
endmodule

// File: tb/tb_fb_write_engine.sv
// Directed bench for fb_write_engine: one window-gated instance and one dual-port instance.
module tb_fb_write_engine;
  logic        clk = 1'b0;
  logic        reset;
  logic        display_on;
  logic        clear_req0, clear_req1;
  logic        mem_we0, mem_we1, busy0, busy1;
  logic [12:0] mem_addr0, mem_addr1;
  logic [2:0]  mem_wdata0, mem_wdata1;
  logic [4:0]  level0, level1;
  logic [7:0]  drop_cnt0, drop_cnt1;
  int vectors = 0;
  int miscompares = 0;

  fb_wr_if #(.HPOS_WIDTH(10), .VPOS_WIDTH(10), .RGB_WIDTH(3)) bus0 ();
  fb_wr_if #(.HPOS_WIDTH(10), .VPOS_WIDTH(10), .RGB_WIDTH(3)) bus1 ();

  fb_write_engine #(.DUAL_PORT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .display_on(display_on), .clear_req(clear_req0), .wr(bus0.slave),
    .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .busy(busy0),
    .level(level0), .drop_cnt(drop_cnt0));

  fb_write_engine #(.DUAL_PORT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .display_on(display_on), .clear_req(clear_req1), .wr(bus1.slave),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .busy(busy1),
    .level(level1), .drop_cnt(drop_cnt1));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic drive0(input logic v, input int h, input int y, input logic [2:0] c);
    bus0.wr_valid = v;
    bus0.wr_hpos  = 10'(h);
    bus0.wr_vpos  = 10'(y);
    bus0.wr_rgb   = c;
  endtask

  initial begin
    int good;
    int bad;
    int exp_addr;
    logic prev_disp;
    logic done;

    reset = 1'b1; display_on = 1'b0; clear_req0 = 1'b0; clear_req1 = 1'b0;
    drive0(1'b0, 0, 0, 3'd0);
    bus1.wr_valid = 1'b0; bus1.wr_hpos = 10'd0; bus1.wr_vpos = 10'd0; bus1.wr_rgb = 3'd0;
    step(); step();
    check("rst_mem_we", 32'(mem_we0), 32'd0);
    check("rst_mem_addr", 32'(mem_addr0), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata0), 32'd0);
    check("rst_wr_ready", 32'(bus0.wr_ready), 32'd0);
    check("rst_level", 32'(level0), 32'd0);
    check("rst_drop", 32'(drop_cnt0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd1);

    // Power-on clear with the window open: 4800 back-to-back writes of 3'b111.
    reset = 1'b0;
    good = 0;
    for (int i = 0; i < 4800; i++) begin
      step();
      if (mem_we0 === 1'b1 && mem_addr0 === 13'(i) && mem_wdata0 === 3'b111) good++;
    end
    check("clear1_writes", 32'(good), 32'd4800);
    check("clear1_busy", 32'(busy0), 32'd0);
    check("clear1_ready", 32'(bus0.wr_ready), 32'd1);
    check("clear1_dp_busy", 32'(busy1), 32'd0);

    // Request held while video is active, drained one cycle after blanking.
    display_on = 1'b1;
    step();
    check("run_idle_we", 32'(mem_we0), 32'd0);
    drive0(1'b1, 17, 9, 3'b010);
    step();
    drive0(1'b0, 0, 0, 3'd0);
    check("held_level", 32'(level0), 32'd1);
    step();
    check("held_we", 32'(mem_we0), 32'd0);
    display_on = 1'b0;
    step();
    check("drain_we", 32'(mem_we0), 32'd1);
    check("drain_addr", 32'(mem_addr0), 32'd82);
    check("drain_data", 32'(mem_wdata0), 32'd2);
    check("drain_level", 32'(level0), 32'd0);
    step();
    check("drain_we_off", 32'(mem_we0), 32'd0);
    check("drain_addr_hold", 32'(mem_addr0), 32'd82);

    // Fill to full while video is active; the 17th request must bounce.
    display_on = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive0(1'b1, i * 8, 16, 3'(i));
      step();
    end
    check("full_level", 32'(level0), 32'd16);
    check("full_ready", 32'(bus0.wr_ready), 32'd0);
    drive0(1'b1, 200, 16, 3'd7);
    step();
    drive0(1'b0, 0, 0, 3'd0);
    check("full_no_overwrite", 32'(level0), 32'd16);
    display_on = 1'b0;
    good = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (mem_we0 === 1'b1 && mem_addr0 === 13'(160 + i) && mem_wdata0 === 3'(i)) good++;
    end
    check("burst_in_order", 32'(good), 32'd16);
    step();
    check("burst_end_we", 32'(mem_we0), 32'd0);
    check("burst_end_level", 32'(level0), 32'd0);

    // Range boundaries and drop counter saturation.
    drive0(1'b1, 640, 0, 3'd1);
    step();
    drive0(1'b0, 0, 0, 3'd0);
    check("oob_h_drop", 32'(drop_cnt0), 32'd1);
    check("oob_h_level", 32'(level0), 32'd0);
    step();
    check("oob_h_no_we", 32'(mem_we0), 32'd0);
    drive0(1'b1, 639, 479, 3'd3);
    step();
    drive0(1'b0, 0, 0, 3'd0);
    check("edge_level", 32'(level0), 32'd1);
    step();
    check("edge_we", 32'(mem_we0), 32'd1);
    check("edge_addr", 32'(mem_addr0), 32'd4799);
    check("edge_data", 32'(mem_wdata0), 32'd3);
    drive0(1'b1, 0, 480, 3'd1);
    step();
    check("oob_v_drop", 32'(drop_cnt0), 32'd2);
    drive0(1'b1, 640, 0, 3'd1);
    for (int i = 0; i < 300; i++) step();
    drive0(1'b0, 0, 0, 3'd0);
    check("drop_saturate", 32'(drop_cnt0), 32'd255);
    check("drop_ready", 32'(bus0.wr_ready), 32'd1);

    // Flush on clear_req with five pending; a same-edge request is refused.
    display_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive0(1'b1, 8 * i, 0, 3'd4);
      step();
    end
    check("pre_clear_level", 32'(level0), 32'd5);
    clear_req0 = 1'b1;
    step();
    clear_req0 = 1'b0;
    drive0(1'b0, 0, 0, 3'd0);
    check("flush_level", 32'(level0), 32'd0);
    check("flush_busy", 32'(busy0), 32'd1);
    check("flush_ready", 32'(bus0.wr_ready), 32'd0);
    check("flush_we", 32'(mem_we0), 32'd0);

    // Clear replay with the window toggling; writes only in blanking, contiguous.
    exp_addr = 0; bad = 0; done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      display_on = ((c % 4) == 0);
      prev_disp = display_on;
      step();
      if (mem_we0 === 1'b1) begin
        if (prev_disp !== 1'b0 || mem_addr0 !== 13'(exp_addr) || mem_wdata0 !== 3'b111) bad++;
        exp_addr++;
      end
      if (busy0 === 1'b0) done = 1'b1;
    end
    check("clear2_writes", 32'(exp_addr), 32'd4800);
    check("clear2_bad", 32'(bad), 32'd0);
    check("clear2_busy", 32'(busy0), 32'd0);
    check("clear2_level", 32'(level0), 32'd0);

    // Dual-port instance drains while video is active.
    display_on = 1'b1;
    bus1.wr_valid = 1'b1; bus1.wr_hpos = 10'd17; bus1.wr_vpos = 10'd9; bus1.wr_rgb = 3'd5;
    step();
    bus1.wr_valid = 1'b0;
    check("dp_level", 32'(level1), 32'd1);
    step();
    check("dp_we", 32'(mem_we1), 32'd1);
    check("dp_addr", 32'(mem_addr1), 32'd82);
    check("dp_data", 32'(mem_wdata1), 32'd5);

    // Reset in the middle of a clear sweep.
    display_on = 1'b0;
    clear_req0 = 1'b1;
    step();
    clear_req0 = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      step();
      if (mem_we0 === 1'b1 && mem_addr0 === 13'd1000) done = 1'b1;
    end
    check("reach_addr_1000", 32'(done), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_we", 32'(mem_we0), 32'd0);
    check("async_rst_addr", 32'(mem_addr0), 32'd0);
    check("async_rst_busy", 32'(busy0), 32'd1);
    check("async_rst_drop", 32'(drop_cnt0), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("restart_we", 32'(mem_we0), 32'd1);
    check("restart_addr", 32'(mem_addr0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
